// File: rtl/mem_access_unit_pkg.sv
// cpu_pkg: shared types and constants for the MEM-stage access unit.
//   state_t          access sequencer states (IDLE, BUSY, DONE)
//   REG_W, DATA_W    register-index and datapath widths
//   MISALIGN_LD_DATA load-data value presented after a misaligned or
//                    timed-out access
package cpu_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] MISALIGN_LD_DATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Takes EX/MEM outputs, runs load/store transactions on the data-memory
// req/ack bus, stalls the pipeline while a transaction is in flight and
// presents the write-back value plus pass-through control to MEM/WB.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   alu_out_in        ALU result / memory byte address
//   wr_data_in        store data
//   mem_rd_in/mem_wr_in load / store request (both set = store)
//   reg_dst_in, reg_wr_in, wb_sel_in  control passed through to MEM/WB
//   dmem_req/we/addr/wdata  memory request bus (held until ack)
//   dmem_rdata, dmem_ack    memory response (ack is a 1-cycle strobe)
//   wb_data_out       write-back value to MEM/WB alu_out_in
//   reg_dst_out, reg_wr_out, wb_sel_out  combinational pass-through
//   mem_stall         pipeline stall
//   mem_err           sticky misalign/timeout flag, cleared by reset only
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [REG_W-1:0]  reg_dst_in,
  input  logic              reg_wr_in,
  input  logic              wb_sel_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_W-1:0]  reg_dst_out,
  output logic              reg_wr_out,
  output logic              wb_sel_out,
  output logic              mem_stall,
  output logic              mem_err
);

  // Counter value on the last permitted BUSY cycle; the access times out
  // when this cycle also passes without an ack (ACK_TIMEOUT BUSY cycles).
  localparam logic [7:0] LP_CNT_LAST = 8'(ACK_TIMEOUT - 32'd1);

  state_t              r_state;
  logic                r_req;
  logic                r_we;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_ld;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic                r_is_rd;

  logic                w_access;
  logic                w_aligned;

  assign w_access  = mem_rd_in | mem_wr_in;
  assign w_aligned = (alu_out_in[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ld    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_is_rd <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_aligned) begin
              r_req   <= 1'b1;
              r_we    <= mem_wr_in;
              r_addr  <= {alu_out_in[DATA_W-1:2], 2'b00};
              r_wdata <= wr_data_in;
              r_cnt   <= '0;
              // A simultaneous rd+wr is a store: no load data captured.
              r_is_rd <= mem_rd_in & ~mem_wr_in;
              r_state <= ST_BUSY;
            end else begin
              r_err   <= 1'b1;
              r_ld    <= MISALIGN_LD_DATA;
              r_state <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          // Ack is checked first so an ack on the timeout cycle wins.
          if (dmem_ack) begin
            if (r_is_rd) begin
              r_ld <= dmem_rdata;
            end
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == LP_CNT_LAST) begin
              r_req   <= 1'b0;
              r_we    <= 1'b0;
              r_err   <= 1'b1;
              r_ld    <= MISALIGN_LD_DATA;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_stall   = 1'b0;
    wb_data_out = alu_out_in;
    unique case (r_state)
      ST_IDLE: mem_stall = w_access;
      ST_BUSY: mem_stall = 1'b1;
      ST_DONE: begin
        mem_stall   = 1'b0;
        wb_data_out = wb_sel_in ? r_ld : alu_out_in;
      end
      default: mem_stall = 1'b0;
    endcase
  end

  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign mem_err     = r_err;
  assign reg_dst_out = reg_dst_in;
  assign reg_wr_out  = reg_wr_in;
  assign wb_sel_out  = wb_sel_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ACK_TIMEOUT overridden to 4).
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_out_in;
  logic [31:0] wr_data_in;
  logic        mem_rd_in;
  logic        mem_wr_in;
  logic [3:0]  reg_dst_in;
  logic        reg_wr_in;
  logic        wb_sel_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] wb_data_out;
  logic [3:0]  reg_dst_out;
  logic        reg_wr_out;
  logic        wb_sel_out;
  logic        mem_stall;
  logic        mem_err;

  int n_chk;
  int n_fail;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_out_in  (alu_out_in),
    .wr_data_in  (wr_data_in),
    .mem_rd_in   (mem_rd_in),
    .mem_wr_in   (mem_wr_in),
    .reg_dst_in  (reg_dst_in),
    .reg_wr_in   (reg_wr_in),
    .wb_sel_in   (wb_sel_in),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .wb_data_out (wb_data_out),
    .reg_dst_out (reg_dst_out),
    .reg_wr_out  (reg_wr_out),
    .wb_sel_out  (wb_sel_out),
    .mem_stall   (mem_stall),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs for the new cycle
  // are driven here and outputs checked 2 time units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [3:0] dst,
                       input logic rw, input logic sel);
    mem_rd_in  = rd;
    mem_wr_in  = wr;
    alu_out_in = alu;
    wr_data_in = wd;
    reg_dst_in = dst;
    reg_wr_in  = rw;
    wb_sel_in  = sel;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Reset state
    #3;
    chk("rst_req",   {31'b0, dmem_req}, 32'h0);
    chk("rst_we",    {31'b0, dmem_we},  32'h0);
    chk("rst_addr",  dmem_addr,         32'h0);
    chk("rst_wdata", dmem_wdata,        32'h0);
    chk("rst_err",   {31'b0, mem_err},  32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op: no access
    cyc();
    drive(1'b0, 1'b0, 32'h1234, 32'h0, 4'h5, 1'b1, 1'b0);
    #2;
    chk("alu_stall", {31'b0, mem_stall}, 32'h0);
    chk("alu_wb",    wb_data_out,        32'h1234);
    chk("alu_req",   {31'b0, dmem_req},  32'h0);
    chk("alu_dst",   {28'b0, reg_dst_out}, 32'h5);
    cyc();
    #2;
    chk("alu_req2",  {31'b0, dmem_req},  32'h0);

    // Load 0x100, ack on third BUSY cycle
    cyc();
    drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h3, 1'b1, 1'b1);
    #2;
    chk("ld_idle_stall", {31'b0, mem_stall}, 32'h1);
    chk("ld_idle_req",   {31'b0, dmem_req},  32'h0);
    cyc();
    #2;
    chk("ld_b1_req",   {31'b0, dmem_req},  32'h1);
    chk("ld_b1_we",    {31'b0, dmem_we},   32'h0);
    chk("ld_b1_addr",  dmem_addr,          32'h100);
    chk("ld_b1_stall", {31'b0, mem_stall}, 32'h1);
    cyc();
    #2;
    chk("ld_b2_stall", {31'b0, mem_stall}, 32'h1);
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #2;
    chk("ld_b3_stall", {31'b0, mem_stall}, 32'h1);
    cyc();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #2;
    chk("ld_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("ld_done_wb",    wb_data_out,        32'hCAFEF00D);
    chk("ld_done_req",   {31'b0, dmem_req},  32'h0);
    chk("ld_done_err",   {31'b0, mem_err},   32'h0);

    // Store 0x40, immediate ack, back-to-back after the load
    cyc();
    drive(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'h7, 1'b0, 1'b0);
    #2;
    chk("st_idle_stall", {31'b0, mem_stall}, 32'h1);
    chk("st_regwr",      {31'b0, reg_wr_out}, 32'h0);
    cyc();
    dmem_ack = 1'b1;
    #2;
    chk("st_b1_req",   {31'b0, dmem_req},  32'h1);
    chk("st_b1_we",    {31'b0, dmem_we},   32'h1);
    chk("st_b1_addr",  dmem_addr,          32'h40);
    chk("st_b1_wdata", dmem_wdata,         32'hA5A5A5A5);
    chk("st_b1_stall", {31'b0, mem_stall}, 32'h1);
    cyc();
    dmem_ack = 1'b0;
    #2;
    chk("st_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("st_done_req",   {31'b0, dmem_req},  32'h0);
    chk("st_done_we",    {31'b0, dmem_we},   32'h0);
    chk("st_done_wb",    wb_data_out,        32'h40);
    chk("st_done_regwr", {31'b0, reg_wr_out}, 32'h0);

    // Misaligned load 0x102
    cyc();
    drive(1'b1, 1'b0, 32'h102, 32'h0, 4'h2, 1'b1, 1'b1);
    #2;
    chk("mis_idle_stall", {31'b0, mem_stall}, 32'h1);
    chk("mis_idle_req",   {31'b0, dmem_req},  32'h0);
    chk("mis_idle_err",   {31'b0, mem_err},   32'h0);
    cyc();
    #2;
    chk("mis_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("mis_done_req",   {31'b0, dmem_req},  32'h0);
    chk("mis_done_err",   {31'b0, mem_err},   32'h1);
    chk("mis_done_wb",    wb_data_out,        32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h9, 32'h0, 4'h0, 1'b0, 1'b0);
    #2;
    chk("mis_sticky_err", {31'b0, mem_err},   32'h1);
    chk("mis_after_stall", {31'b0, mem_stall}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_clr_err", {31'b0, mem_err}, 32'h0);
    #1;
    rst_n = 1'b1;

    // Ack on the last permitted BUSY cycle wins over timeout
    cyc();
    drive(1'b1, 1'b0, 32'h400, 32'h0, 4'h4, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      #2;
      chk("race_busy_req", {31'b0, dmem_req}, 32'h1);
    end
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #2;
    chk("race_b4_req", {31'b0, dmem_req}, 32'h1);
    cyc();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #2;
    chk("race_done_wb",    wb_data_out,        32'hDEADBEEF);
    chk("race_done_err",   {31'b0, mem_err},   32'h0);
    chk("race_done_stall", {31'b0, mem_stall}, 32'h0);

    // Timeout: 4 BUSY cycles with no ack
    cyc();
    drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h6, 1'b1, 1'b1);
    #2;
    chk("to_idle_stall", {31'b0, mem_stall}, 32'h1);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc();
      #2;
      chk("to_busy_req",   {31'b0, dmem_req},  32'h1);
      chk("to_busy_stall", {31'b0, mem_stall}, 32'h1);
    end
    cyc();
    dmem_ack = 1'b1;  // stray ack outside BUSY
    #2;
    chk("to_done_req",   {31'b0, dmem_req},  32'h0);
    chk("to_done_err",   {31'b0, mem_err},   32'h1);
    chk("to_done_wb",    wb_data_out,        32'h0);
    chk("to_done_stall", {31'b0, mem_stall}, 32'h0);

    // Later good load completes, error stays set
    cyc();
    dmem_ack = 1'b0;
    drive(1'b1, 1'b0, 32'h300, 32'h0, 4'h1, 1'b1, 1'b1);
    #2;
    chk("ok_idle_req",   {31'b0, dmem_req},  32'h0);
    chk("ok_idle_stall", {31'b0, mem_stall}, 32'h1);
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11223344;
    #2;
    chk("ok_b1_req", {31'b0, dmem_req}, 32'h1);
    cyc();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #2;
    chk("ok_done_wb",  wb_data_out,      32'h11223344);
    chk("ok_done_err", {31'b0, mem_err}, 32'h1);

    // Reset during BUSY
    cyc();
    drive(1'b1, 1'b0, 32'h500, 32'h0, 4'h8, 1'b1, 1'b1);
    cyc();
    #2;
    chk("rb_busy_req", {31'b0, dmem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rb_rst_req",   {31'b0, dmem_req},  32'h0);
    chk("rb_rst_stall", {31'b0, mem_stall}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("rb_rst_stall0", {31'b0, mem_stall}, 32'h0);
    rst_n = 1'b1;
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBADBAD00;
    #2;
    chk("rb_ack_req",   {31'b0, dmem_req},  32'h0);
    chk("rb_ack_stall", {31'b0, mem_stall}, 32'h0);
    cyc();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h77, 32'h0, 4'h0, 1'b0, 1'b1);
    #2;
    chk("rb_after_wb",    wb_data_out,        32'h77);
    chk("rb_after_req",   {31'b0, dmem_req},  32'h0);
    chk("rb_after_stall", {31'b0, mem_stall}, 32'h0);
    chk("rb_after_err",   {31'b0, mem_err},   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
